// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Releases NUM_STAGES active-high reset lines in order, spaced
//               STEP_CYCLES edges apart, after the board button is released.
//               A software request re-asserts the stages in reverse order,
//               holds them for HOLD_CYCLES edges, then replays the release.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int STEP_CYCLES = 1,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                  clk_1Hz,
  input  logic                  button_rst,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  done,
  output logic [1:0]            state
);

  localparam logic [1:0] S_RELEASE = 2'd0;
  localparam logic [1:0] S_DONE    = 2'd1;
  localparam logic [1:0] S_ASSERT  = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  // Counter value reached on the edge that ends each timed phase.
  localparam logic [CNT_W-1:0] C_RELEASE_END = CNT_W'(NUM_STAGES * STEP_CYCLES);
  localparam logic [CNT_W-1:0] C_ASSERT_END  = CNT_W'((NUM_STAGES - 1) * STEP_CYCLES);
  localparam logic [CNT_W-1:0] C_HOLD_END    = CNT_W'(HOLD_CYCLES);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [NUM_STAGES-1:0] r_rst;
  logic [NUM_STAGES-1:0] w_rst_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic [NUM_STAGES-1:0] w_rel_hit;
  logic [NUM_STAGES-1:0] w_asr_hit;

  // Counter value as it will be after this edge; stage timing compares use it
  // so that the first edge of a phase counts as edge 1.
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Per-stage hit flags: stage i releases at (i+1)*STEP, and during the
  // reverse sweep stage NUM_STAGES-1-k asserts at k*STEP.
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    localparam logic [CNT_W-1:0] C_REL_AT = CNT_W'((i + 1) * STEP_CYCLES);
    assign w_rel_hit[i] = (w_cnt_inc == C_REL_AT);
    if (i == NUM_STAGES - 1) begin : g_top
      // Top stage is asserted directly on the request edge.
      assign w_asr_hit[i] = 1'b0;
    end else begin : g_low
      localparam logic [CNT_W-1:0] C_ASR_AT = CNT_W'((NUM_STAGES - 1 - i) * STEP_CYCLES);
      assign w_asr_hit[i] = (w_cnt_inc == C_ASR_AT);
    end
  end

  // State, counter and registered outputs; button reset acts immediately.
  always_ff @(posedge clk_1Hz or negedge button_rst) begin
    if (!button_rst) begin
      r_state <= S_RELEASE;
      r_cnt   <= '0;
      r_rst   <= '1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rst   <= w_rst_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Phase sequencing; the counter restarts from zero on every phase change.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_inc;
    case (r_state)
      S_RELEASE: begin
        if (w_cnt_inc == C_RELEASE_END) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end
      end
      S_DONE: begin
        w_cnt_nxt = '0;
        if (sw_rst_req) begin
          w_state_nxt = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (w_cnt_inc == C_ASSERT_END) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        if (w_cnt_inc == C_HOLD_END) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  // Next reset vector: released stages stay released, asserted ones stay set.
  always_comb begin
    w_rst_nxt = r_rst;
    case (r_state)
      S_RELEASE: w_rst_nxt = r_rst & ~w_rel_hit;
      S_DONE:    w_rst_nxt = sw_rst_req ? {1'b1, {(NUM_STAGES-1){1'b0}}} : '0;
      S_ASSERT:  w_rst_nxt = r_rst | w_asr_hit;
      default:   w_rst_nxt = '1;
    endcase
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  assign rst_out = r_rst;
  assign done    = r_done;
  assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Scoreboard bench for reset_sequencer, default build plus a
//               two-stage build with STEP_CYCLES=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

  logic       clk_1Hz    = 1'b0;
  logic       button_rst = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic [3:0] rst_a;
  logic       done_a;
  logic [1:0] state_a;
  logic [1:0] rst_b;
  logic       done_b;
  logic [1:0] state_b;

  always #5 clk_1Hz = ~clk_1Hz;

  reset_sequencer dut_a (
    .clk_1Hz    (clk_1Hz),
    .button_rst (button_rst),
    .sw_rst_req (sw_rst_req),
    .rst_out    (rst_a),
    .done       (done_a),
    .state      (state_a)
  );

  reset_sequencer #(
    .NUM_STAGES  (2),
    .STEP_CYCLES (3),
    .HOLD_CYCLES (2),
    .CNT_W       (8)
  ) dut_b (
    .clk_1Hz    (clk_1Hz),
    .button_rst (button_rst),
    .sw_rst_req (sw_rst_req),
    .rst_out    (rst_b),
    .done       (done_b),
    .state      (state_b)
  );

  typedef struct packed {
    logic [3:0] rst;
    logic       done;
    logic [1:0] st;
  } exp_t;

  localparam int NS [2] = '{4, 2};
  localparam int SS [2] = '{1, 3};
  localparam int HS [2] = '{2, 2};

  // plan: upcoming per-edge responses of a sequence in flight.
  // exp_q: responses due for checking by the monitor.
  exp_t plan  [2][$];
  exp_t exp_q [2][$];
  int   compared   = 0;
  int   mismatched = 0;
  event chk_ev;

  function automatic logic [3:0] ones(int n);
    return 4'((1 << n) - 1);
  endfunction

  task automatic push_release(int d);
    for (int e = 1; e <= NS[d] * SS[d]; e++) begin
      exp_t x;
      x.rst = 4'b0000;
      for (int i = 0; i < NS[d]; i++)
        if (e < (i + 1) * SS[d]) x.rst = x.rst | (4'b0001 << i);
      x.done = (e == NS[d] * SS[d]);
      x.st   = x.done ? 2'd1 : 2'd0;
      plan[d].push_back(x);
    end
  endtask

  task automatic push_sw_cycle(int d);
    exp_t x;
    for (int e = 0; e <= (NS[d] - 1) * SS[d]; e++) begin
      x.rst = 4'b0000;
      for (int j = 0; j < NS[d]; j++)
        if (j >= NS[d] - 1 - e / SS[d]) x.rst = x.rst | (4'b0001 << j);
      x.done = 1'b0;
      x.st   = (e == (NS[d] - 1) * SS[d]) ? 2'd3 : 2'd2;
      plan[d].push_back(x);
    end
    for (int h = 1; h <= HS[d]; h++) begin
      x.rst  = ones(NS[d]);
      x.done = 1'b0;
      x.st   = (h == HS[d]) ? 2'd0 : 2'd3;
      plan[d].push_back(x);
    end
    push_release(d);
  endtask

  task automatic model_edge(int d, logic sw);
    exp_t x;
    if (plan[d].size() == 0) begin
      if (sw) begin
        push_sw_cycle(d);
      end else begin
        x.rst = 4'b0000; x.done = 1'b1; x.st = 2'd1;
        plan[d].push_back(x);
      end
    end
    exp_q[d].push_back(plan[d].pop_front());
  endtask

  task automatic push_reset_entries();
    exp_t x;
    for (int d = 0; d < 2; d++) begin
      x.rst = ones(NS[d]); x.done = 1'b0; x.st = 2'd0;
      exp_q[d].push_back(x);
    end
  endtask

  task automatic do_edge(logic sw);
    sw_rst_req = sw;
    @(posedge clk_1Hz);
    for (int d = 0; d < 2; d++) begin
      if (!button_rst) push_reset_entries_one(d);
      else model_edge(d, sw);
    end
    #1;
  endtask

  task automatic push_reset_entries_one(int d);
    exp_t x;
    x.rst = ones(NS[d]); x.done = 1'b0; x.st = 2'd0;
    exp_q[d].push_back(x);
  endtask

  // Drop the button and check the outputs without any clock edge.
  task automatic drop_now();
    button_rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      plan[d].delete();
      push_release(d);
    end
    #1;
    push_reset_entries();
    ->chk_ev;
  endtask

  task automatic abort_mid();
    @(negedge clk_1Hz);
    #2;
    drop_now();
  endtask

  task automatic release_rst();
    @(negedge clk_1Hz);
    #1;
    button_rst = 1'b1;
  endtask

  // Monitor: every edge (and on demand) compares each DUT to its queue head.
  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(negedge clk_1Hz or chk_ev);
      for (int d = 0; d < 2; d++) begin
        if (exp_q[d].size() > 0) begin
          e = exp_q[d].pop_front();
          g = (d == 0) ? {rst_a, done_a, state_a} : {2'b00, rst_b, done_b, state_b};
          compared++;
          if (g !== e) begin
            mismatched++;
            $display("FAIL dut%0d outputs @%0t: got rst_out=%b done=%b state=%0d, required rst_out=%b done=%b state=%0d",
                     d, $time, g.rst, g.done, g.st, e.rst, e.done, e.st);
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by a randomized run.
  initial begin
    int n;
    #2;
    drop_now();
    repeat (3) do_edge(1'b0);
    release_rst();
    // Power-on release with a request ignored on edge 2.
    do_edge(1'b0);
    do_edge(1'b1);
    repeat (10) do_edge(1'b0);
    // Software reset pulse, plus an ignored pulse during HOLD.
    do_edge(1'b1);
    repeat (3) do_edge(1'b0);
    do_edge(1'b1);
    repeat (10) do_edge(1'b0);
    // Request, then abort between A+1 and A+2.
    do_edge(1'b1);
    do_edge(1'b0);
    abort_mid();
    do_edge(1'b1);
    do_edge(1'b0);
    release_rst();
    repeat (10) do_edge(1'b0);
    // Continuous request.
    repeat (30) do_edge(1'b1);
    repeat (14) do_edge(1'b0);
    // Randomized run.
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 49) == 0) begin
        abort_mid();
        n = int'($urandom_range(1, 3));
        repeat (n) do_edge($urandom_range(0, 1) == 1);
        release_rst();
      end else begin
        do_edge($urandom_range(0, 3) == 0);
      end
    end
    for (int i = 0; i < 5 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); i++)
      @(negedge clk_1Hz);
    #1;
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d/%0d entries left, required 0/0", exp_q[0].size(), exp_q[1].size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset sequencer that releases `NUM_STAGES` active-high reset lines in a fixed order, `STEP_CYCLES` clock edges apart, after the asynchronous board button is released. Stage 0 is the earliest domain (program counter). The highest stage is the latest (clock divider / peripherals). Unlike the two-output fixed sequencer, it supports a software reset request. That request re-asserts the stages in reverse order, holds them, then replays the release sequence. It runs on the slow system clock and drives the reset inputs of the CPU datapath blocks.

## Interface
- `NUM_STAGES`, default 4: number of sequenced reset outputs; must be ≥2.
- `STEP_CYCLES`, default 1: clock edges between successive stage changes; must be ≥1.
- `HOLD_CYCLES`, default 2: edges all stages stay asserted before re-release; must be ≥1.
- `CNT_W`, default 8: internal counter width.
  - Must satisfy `NUM_STAGES*STEP_CYCLES < 2^CNT_W`.
  - Must satisfy `HOLD_CYCLES < 2^CNT_W`.
- `clk_1Hz`, input, 1: system clock; all logic on its rising edge.
- `button_rst`, input, 1: reset, asynchronous, active-low.
- `sw_rst_req`, input, 1: synchronous software reset request; level sampled each edge.
- `rst_out`, output, `NUM_STAGES`: per-stage reset, active-high; bit i = stage i.
- `done`, output, 1: high when all stages are released and the block is idle.
- `state`, output, 2: debug state code.
  - RELEASE = 0, DONE = 1, ASSERT = 2, HOLD = 3.

## Operation
- **Reset (`button_rst` = 0, asynchronous, any state)**
  - `rst_out` = all ones, `done` = 0, `state` = RELEASE, counter = 0.
  - Simulation initial values are identical.
- **RELEASE**
  - Counter increments each edge.
  - Stage i deasserts on edge (i+1)·`STEP_CYCLES`, counting the first edge after reset removal (or after HOLD exit) as edge 1.
  - A released stage never re-asserts within RELEASE.
  - When stage `NUM_STAGES`-1 deasserts, go to DONE on that same edge: `done` = 1 and counter = 0 on that edge.
- **DONE**
  - `rst_out` = 0 and `done` = 1.
  - If `sw_rst_req` = 1 at an edge (edge A):
    - go to ASSERT;
    - `rst_out[NUM_STAGES-1]` = 1 and `done` = 0 on edge A;
    - counter = 0.
- **ASSERT**
  - Stage `NUM_STAGES`-1-k asserts on edge A + k·`STEP_CYCLES`, for k = 1..`NUM_STAGES`-1.
  - Edge B is the edge that asserts stage 0. On edge B: go to HOLD, counter = 0.
- **HOLD**
  - All `rst_out` = 1.
  - On edge B + `HOLD_CYCLES`: go to RELEASE with counter = 0.
  - Stage i then deasserts on edge B + `HOLD_CYCLES` + (i+1)·`STEP_CYCLES`.
- **`sw_rst_req` handling**
  - Ignored in RELEASE, ASSERT and HOLD; no queuing.
  - Held high continuously: a new ASSERT starts on the first edge in DONE after re-release completes, i.e. one edge after `done` rises.
- **Counter arithmetic**
  - Unsigned, `CNT_W` bits.
  - Compares use exact equality against constants computed from the parameters.
  - Never wraps under the legal parameter constraint.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Assertion of `button_rst` forces outputs immediately (asynchronously).
- Deassertion of `button_rst` takes effect on the next rising edge (edge 1).
- Defaults (`NUM_STAGES`=4, `STEP_CYCLES`=1), after `button_rst` rises:

  | Edge | Event |
  |---|---|
  | 1 | `rst_out` = 1110 |
  | 2 | `rst_out` = 1100 |
  | 3 | `rst_out` = 1000 |
  | 4 | `rst_out` = 0000, `done` = 1 |

  - Total release latency = `NUM_STAGES`·`STEP_CYCLES` edges.
- Software reset latency:
  - Request to first assertion: 0 edges (same edge it is sampled).
  - Request to stage 0 asserted: (`NUM_STAGES`-1)·`STEP_CYCLES` edges.
  - Full cycle back to `done` = 1: (`NUM_STAGES`-1)·`STEP_CYCLES` + `HOLD_CYCLES` + `NUM_STAGES`·`STEP_CYCLES` edges. With defaults this is 3 + 2 + 4 = 9 edges.
- `button_rst` asserted mid-ASSERT, HOLD or RELEASE:
  - Immediate full reset.
  - The sequence restarts from edge 1 after release.
  - Partial progress is discarded.
- `button_rst` low while `sw_rst_req` is high: reset wins. After release, the request is ignored until DONE.

## Test plan
1. **Defaults, power-on**
   - Stimulus: hold `button_rst`=0 for 3 edges, then set it to 1.
   - Required response: `rst_out` = 1111, then 1110, 1100, 1000, 0000 on edges 1–4. `done`=1 at edge 4. `state` = 0,0,0,1.
2. **`STEP_CYCLES`=3, `NUM_STAGES`=2**
   - Required response: stage 0 releases at edge 3. Stage 1 and `done` at edge 6. `rst_out` is unchanged on all other edges.
3. **Software reset, defaults**
   - Stimulus: one-edge `sw_rst_req` pulse at edge A while in DONE.
   - Required response:
     - `rst_out` = 1000 at A, 1100 at A+1, 1110 at A+2, 1111 at A+3 (`state`=3).
     - Holds 1111 through A+5.
     - Then 1110 at A+6 … 0000 with `done`=1 at A+9.
4. **Request ignored**
   - Stimulus: pulse `sw_rst_req` at edge 2 of the power-on release, and again during HOLD.
   - Required response: sequence timing is identical to scenarios 1 and 3.
5. **Async abort**
   - Stimulus: drop `button_rst` midway between edges A+1 and A+2 of scenario 3.
   - Required response: `rst_out`=1111 and `done`=0 immediately, with no clock. After release, scenario-1 timing applies.
6. **Continuous request**
   - Stimulus: `sw_rst_req` held at 1.
   - Required response: `done` is high for exactly one edge, then the next ASSERT begins. The period is 10 edges with defaults.
